// File: rtl/audioport_pkg.sv
// rtl/audioport_pkg.sv - shared types and constants for the audioport APB command master
package audioport_pkg;

    typedef enum logic [1:0] {APB_IDLE, APB_SETUP, APB_ACCESS} apb_master_state_t;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
    } apb_req_t;

    localparam int APB_MASTER_TIMEOUT = 16;

    function automatic logic is_aligned(input logic [1:0] lsb);
        return lsb == 2'b00;
    endfunction

endpackage

// File: rtl/apb_req_fifo.sv
// rtl/apb_req_fifo.sv - request FIFO with a looped bit; also exposes the entry behind the head
module apb_req_fifo
    import audioport_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  apb_req_t push_data,
    input  logic     pop,
    output logic     full,
    output logic     empty,
    output apb_req_t head,
    output logic     second_valid,
    output apb_req_t second
);
    localparam int AW = $clog2(DEPTH);

    apb_req_t      mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_next;
    logic          looped;
    logic          do_push;
    logic          do_pop;
    logic          wr_wrap;
    logic          rd_wrap;

    assign full    = (wr_ptr == rd_ptr) && looped;
    assign empty   = (wr_ptr == rd_ptr) && !looped;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign wr_wrap = do_push && (wr_ptr == AW'(DEPTH - 1));
    assign rd_wrap = do_pop && (rd_ptr == AW'(DEPTH - 1));
    assign rd_next = rd_ptr + AW'(1);

    assign head         = mem[rd_ptr];
    assign second       = mem[rd_next];
    assign second_valid = !empty && ((rd_next != wr_ptr) || full);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            looped <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_next;
            looped <= looped ^ wr_wrap ^ rd_wrap;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/apb_cmd_master.sv
// rtl/apb_cmd_master.sv - APB3 initiator fed by a buffered request stream, one response per request
// Optional ACCESS timeout enabled by defining APB_TIMEOUT_EN.
module apb_cmd_master
    import audioport_pkg::*;
#(
    parameter int REQ_FIFO_DEPTH = 4
`ifdef APB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = APB_MASTER_TIMEOUT
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR
);
    apb_master_state_t state_q, state_d;
    logic        psel_d, penable_d, pwrite_d;
    logic [31:0] paddr_d, pwdata_d;
    logic        rsp_valid_d, rsp_err_d;
    logic [31:0] rsp_rdata_d;
    logic        run_q;
    logic        pop, full, empty, second_valid, push_fire;
    logic        next_valid, tmo_hit;
    apb_req_t    head, second, in_req, next_head;

    // Held low through reset and the first clock so every output reads 0 in reset.
    assign req_ready = run_q && !full;
    assign push_fire = req_valid && req_ready;
    assign in_req    = '{write: req_write, addr: req_addr, wdata: req_wdata};
    assign busy      = !empty || (state_q != APB_IDLE);

    apb_req_fifo #(.DEPTH(REQ_FIFO_DEPTH)) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push         (push_fire),
        .push_data    (in_req),
        .pop          (pop),
        .full         (full),
        .empty        (empty),
        .head         (head),
        .second_valid (second_valid),
        .second       (second)
    );

    // Head after the current pop: the queued follower, or a request arriving this cycle.
    assign next_valid = second_valid || push_fire;
    assign next_head  = second_valid ? second : in_req;

`ifdef APB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                tmo_cnt <= '0;
        else if (state_q == APB_ACCESS && !PREADY) tmo_cnt <= tmo_cnt + TW'(1);
        else                                       tmo_cnt <= '0;
    end

    assign tmo_hit = (state_q == APB_ACCESS) && !PREADY && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        psel_d      = PSEL;
        penable_d   = PENABLE;
        pwrite_d    = PWRITE;
        paddr_d     = PADDR;
        pwdata_d    = PWDATA;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        pop         = 1'b0;
        unique case (state_q)
            APB_IDLE: begin
                if (!empty) begin
                    if (is_aligned(head.addr[1:0])) begin
                        state_d  = APB_SETUP;
                        psel_d   = 1'b1;
                        pwrite_d = head.write;
                        paddr_d  = head.addr;
                        pwdata_d = head.write ? head.wdata : '0;
                    end else begin
                        pop         = 1'b1;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end
                end
            end
            APB_SETUP: begin
                state_d   = APB_ACCESS;
                penable_d = 1'b1;
            end
            APB_ACCESS: begin
                if (PREADY || tmo_hit) begin
                    pop         = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = PREADY ? PSLVERR : 1'b1;
                    rsp_rdata_d = (PREADY && !PWRITE && !PSLVERR) ? PRDATA : '0;
                    if (PREADY && next_valid && is_aligned(next_head.addr[1:0])) begin
                        state_d   = APB_SETUP;
                        penable_d = 1'b0;
                        pwrite_d  = next_head.write;
                        paddr_d   = next_head.addr;
                        pwdata_d  = next_head.write ? next_head.wdata : '0;
                    end else begin
                        state_d   = APB_IDLE;
                        psel_d    = 1'b0;
                        penable_d = 1'b0;
                        pwrite_d  = 1'b0;
                        paddr_d   = '0;
                        pwdata_d  = '0;
                    end
                end
            end
            default: state_d = APB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= APB_IDLE;
            run_q     <= 1'b0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state_q   <= state_d;
            run_q     <= 1'b1;
            PSEL      <= psel_d;
            PENABLE   <= penable_d;
            PWRITE    <= pwrite_d;
            PADDR     <= paddr_d;
            PWDATA    <= pwdata_d;
            rsp_valid <= rsp_valid_d;
            rsp_err   <= rsp_err_d;
            rsp_rdata <= rsp_rdata_d;
        end
    end

endmodule
